pipe_pattern_engine: RTL and testbench

//  Parametrised traffic generator/checker for pipe throughput and integrity tests on sys_clk.

---
 rtl/pipe_pattern_engine.sv | 160 ++++++++++++++++
 tb/tb_pipe_pattern_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_pattern_engine.sv
// Pattern generator/checker for pipe throughput and integrity tests on sys_clk.
// The generator feeds the F2P FIFO, and the checker drains the P2F FIFO against the same pattern.
module pipe_pattern_engine #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    input  logic [CNT_W-1:0]  gen_len,
    input  logic [CNT_W-1:0]  chk_len,
    input  logic              start,
    input  logic              stop,
    input  logic              gen_full,
    output logic              gen_wr_en,
    output logic [DATA_W-1:0] gen_din,
    input  logic              chk_empty,
    output logic              chk_rd_en,
    input  logic [DATA_W-1:0] chk_dout,
    input  logic              chk_valid,
    output logic [CNT_W-1:0]  gen_count,
    output logic [CNT_W-1:0]  chk_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic              err_flag,
    output logic              gen_done,
    output logic              chk_done
);

    localparam int LANES = DATA_W / 32;

    // DRAIN is the one checker cycle after stop that still accepts a late chk_valid.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m, input logic [31:0] s);
        logic [31:0] lane;
        lane = (m == 2'b01 && s == 32'h0) ? 32'h1 : s;
        case (m)
            2'b01, 2'b10: return {LANES{lane}};
            default:      return DATA_W'(s);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m, input logic [DATA_W-1:0] w);
        case (m)
            2'b01:   return {LANES{lfsr_step(w[31:0])}};
            2'b10:   return w;
            default: return w + DATA_W'(1);
        endcase
    endfunction

    // Generator
    state_t            gen_state;
    logic [1:0]        gen_mode;
    logic [CNT_W-1:0]  gen_len_r;
    logic [DATA_W-1:0] gen_word;

    assign gen_wr_en = (gen_state == RUN) && !gen_full;
    assign gen_din   = gen_word;
    assign gen_done  = (gen_state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            gen_state <= IDLE;
            gen_mode  <= 2'b00;
            gen_len_r <= '0;
            gen_word  <= '0;
            gen_count <= '0;
        end else if (start) begin
            gen_state <= RUN;
            gen_mode  <= mode;
            gen_len_r <= gen_len;
            gen_word  <= first_word(mode, seed);
            gen_count <= '0;
        end else if (gen_state == RUN) begin
            if (gen_wr_en) begin
                gen_count <= gen_count + CNT_W'(1);
                gen_word  <= next_word(gen_mode, gen_word);
            end
            if (stop || (gen_wr_en && gen_len_r != '0 && gen_count + CNT_W'(1) == gen_len_r))
                gen_state <= DONE;
        end
    end

    // Checker
    state_t            chk_state;
    logic [1:0]        chk_mode;
    logic [CNT_W-1:0]  chk_len_r;
    logic [CNT_W-1:0]  issued;
    logic [DATA_W-1:0] exp_word;
    logic              chk_active;
    logic              mismatch;
    logic              last_word;

    assign chk_rd_en  = (chk_state == RUN) && !chk_empty && (chk_len_r == '0 || issued < chk_len_r);
    assign chk_done   = (chk_state == DONE);
    assign chk_active = chk_valid && (chk_state == RUN || chk_state == DRAIN);
    assign mismatch   = chk_active && (chk_dout != exp_word);
    assign last_word  = chk_active && chk_len_r != '0 && chk_count + CNT_W'(1) == chk_len_r;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            chk_state      <= IDLE;
            chk_mode       <= 2'b00;
            chk_len_r      <= '0;
            issued         <= '0;
            exp_word       <= '0;
            chk_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            err_flag       <= 1'b0;
        end else if (start) begin
            chk_state      <= RUN;
            chk_mode       <= mode;
            chk_len_r      <= chk_len;
            issued         <= '0;
            exp_word       <= first_word(mode, seed);
            chk_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            err_flag       <= 1'b0;
        end else begin
            if (chk_rd_en)
                issued <= issued + CNT_W'(1);
            if (chk_active) begin
                chk_count <= chk_count + CNT_W'(1);
                exp_word  <= next_word(chk_mode, exp_word);
            end
            if (mismatch) begin
                if (err_count != {CNT_W{1'b1}})
                    err_count <= err_count + CNT_W'(1);
                if (!err_flag) begin
                    err_flag       <= 1'b1;
                    first_err_idx  <= chk_count;
                    first_err_data <= chk_dout;
                end
            end
            case (chk_state)
                RUN: begin
                    if (last_word)
                        chk_state <= DONE;
                    else if (stop)
                        chk_state <= DRAIN;
                end
                DRAIN:   chk_state <= DONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_pattern_engine.sv
// Bench for pipe_pattern_engine: randomized seeds/modes in loopback through a 16-deep FIFO,
// with every generated word and checker status compared against a pattern model.
module tb_pipe_pattern_engine;

    localparam int DW  = 128;
    localparam int CW  = 32;
    localparam int SCW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, stop;
    logic [1:0]     mode;
    logic [31:0]    seed;
    logic [CW-1:0]  gen_len, chk_len;
    logic           drv_full, drv_empty, drv_valid, loop_en;
    logic [DW-1:0]  drv_dout;

    logic           gen_full, chk_empty, chk_valid;
    logic [DW-1:0]  chk_dout;
    logic           gen_wr_en, chk_rd_en, err_flag, gen_done, chk_done;
    logic [DW-1:0]  gen_din, first_err_data;
    logic [CW-1:0]  gen_count, chk_count, err_count, first_err_idx;

    logic           fifo_valid;
    logic [DW-1:0]  fifo_dout;
    int             fifo_cnt = 0;
    logic [DW-1:0]  fifo_q[$];
    int             wr_seen = 0;
    int             corrupt_a, corrupt_b;

    assign gen_full  = loop_en ? (fifo_cnt >= 16) : drv_full;
    assign chk_empty = loop_en ? (fifo_cnt == 0)  : drv_empty;
    assign chk_valid = loop_en ? fifo_valid       : drv_valid;
    assign chk_dout  = loop_en ? fifo_dout        : drv_dout;

    pipe_pattern_engine #(.DATA_W(DW), .CNT_W(CW)) u_dut (
        .sys_clk(clk), .rst(rst), .mode(mode), .seed(seed), .gen_len(gen_len), .chk_len(chk_len),
        .start(start), .stop(stop), .gen_full(gen_full), .gen_wr_en(gen_wr_en), .gen_din(gen_din),
        .chk_empty(chk_empty), .chk_rd_en(chk_rd_en), .chk_dout(chk_dout), .chk_valid(chk_valid),
        .gen_count(gen_count), .chk_count(chk_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data), .err_flag(err_flag),
        .gen_done(gen_done), .chk_done(chk_done)
    );

    // Narrow instance for counter saturation.
    logic            s_start, s_valid, s_empty;
    logic [SCW-1:0]  s_len;
    logic [31:0]     s_dout, s_gen_din, s_first_data;
    logic            s_wr_en, s_rd_en, s_flag, s_gen_done, s_chk_done;
    logic [SCW-1:0]  s_gen_count, s_chk_count, s_err_count, s_first_idx;

    pipe_pattern_engine #(.DATA_W(32), .CNT_W(SCW)) u_sat (
        .sys_clk(clk), .rst(rst), .mode(mode), .seed(seed), .gen_len(s_len), .chk_len(s_len),
        .start(s_start), .stop(stop), .gen_full(1'b1), .gen_wr_en(s_wr_en), .gen_din(s_gen_din),
        .chk_empty(s_empty), .chk_rd_en(s_rd_en), .chk_dout(s_dout), .chk_valid(s_valid),
        .gen_count(s_gen_count), .chk_count(s_chk_count), .err_count(s_err_count),
        .first_err_idx(s_first_idx), .first_err_data(s_first_data), .err_flag(s_flag),
        .gen_done(s_gen_done), .chk_done(s_chk_done)
    );

    // Loopback FIFO: optional bit-3 corruption of chosen write indices.
    always @(posedge clk) begin
        logic [DW-1:0] w;
        fifo_valid <= 1'b0;
        if (rst || start || !loop_en) begin
            fifo_q.delete();
            fifo_cnt <= 0;
            wr_seen = 0;
        end else begin
            if (chk_rd_en && fifo_q.size() > 0) begin
                fifo_dout  <= fifo_q.pop_front();
                fifo_valid <= 1'b1;
            end
            if (gen_wr_en) begin
                w = gen_din;
                if (wr_seen == corrupt_a || wr_seen == corrupt_b) w[3] = ~w[3];
                fifo_q.push_back(w);
                wr_seen++;
            end
            fifo_cnt <= fifo_q.size();
        end
    end

    // Write monitor: records every accepted generator word.
    logic [DW-1:0] got_q[$];
    int            full_wr = 0;
    always @(negedge clk) begin
        if (start) begin
            got_q.delete();
            full_wr = 0;
        end else if (gen_wr_en) begin
            got_q.push_back(gen_din);
            if (gen_full) full_wr++;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pattern model: word k computed directly from mode/seed.
    logic [DW-1:0] exp_arr[$];
    function automatic void build_exp(input logic [1:0] m, input logic [31:0] s, input int n);
        logic [31:0] lf;
        exp_arr.delete();
        lf = (s == 32'h0) ? 32'h1 : s;
        for (int k = 0; k < n; k++) begin
            case (m)
                2'b01:   exp_arr.push_back({4{lf}});
                2'b10:   exp_arr.push_back({4{s}});
                default: exp_arr.push_back(DW'(s) + DW'(k));
            endcase
            lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
        end
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(gen_done && chk_done) && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", DW'(gen_done && chk_done), 1);
    endtask

    task automatic check_words(input int n);
        check("n_writes", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("gen_din[%0d]", i), got_q[i], exp_arr[i]);
    endtask

    initial begin
        logic [31:0] bad;
        logic [31:0] first_bad;
        int          nerr;
        int          len;

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; seed = '0;
        gen_len = '0; chk_len = '0; drv_full = 1'b0; drv_empty = 1'b1; drv_valid = 1'b0;
        drv_dout = '0; loop_en = 1'b0; corrupt_a = -1; corrupt_b = -1;
        s_start = 1'b0; s_valid = 1'b0; s_dout = '0; s_empty = 1'b1; s_len = '0;
        tick(2);

        // Reset state
        check("rst_wr_en", DW'(gen_wr_en), 0);
        check("rst_rd_en", DW'(chk_rd_en), 0);
        check("rst_gen_din", gen_din, 0);
        check("rst_gen_count", gen_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_flag", DW'(err_flag), 0);
        check("rst_done", DW'({gen_done, chk_done}), 0);
        check("rst_first_data", first_err_data, 0);
        rst = 1'b0;

        // stop while idle is ignored
        pulse_stop();
        tick();
        check("idle_stop_done", DW'({gen_done, chk_done}), 0);

        // Counter pattern, short run, no backpressure
        mode = 2'b00; seed = 32'd5; gen_len = 4; chk_len = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_wr_en[%0d]", i), DW'(gen_wr_en), 1);
            check($sformatf("t1_din[%0d]", i), gen_din, DW'(5 + i));
            check($sformatf("t1_done[%0d]", i), DW'(gen_done), 0);
            tick();
        end
        check("t1_gen_done", DW'(gen_done), 1);
        check("t1_wr_en_off", DW'(gen_wr_en), 0);
        check("t1_gen_count", gen_count, 4);

        // LFSR loopback, seed 0
        loop_en = 1'b1; mode = 2'b01; seed = 32'h0; gen_len = 1000; chk_len = 1000;
        build_exp(2'b01, 32'h0, 1000);
        pulse_start();
        check("t2_first_word", gen_din, {4{32'h1}});
        wait_done(3000);
        check_words(1000);
        check("t2_chk_count", chk_count, 1000);
        check("t2_gen_count", gen_count, 1000);
        check("t2_err_count", err_count, 0);
        check("t2_err_flag", DW'(err_flag), 0);

        // LFSR loopback with words 10 and 20 corrupted
        seed = $urandom; corrupt_a = 10; corrupt_b = 20;
        build_exp(2'b01, seed, 1000);
        pulse_start();
        wait_done(3000);
        check_words(1000);
        check("t3_err_count", err_count, 2);
        check("t3_first_idx", first_err_idx, 10);
        check("t3_first_data", first_err_data, exp_arr[10] ^ DW'(8));
        check("t3_err_flag", DW'(err_flag), 1);
        check("t3_chk_count", chk_count, 1000);
        corrupt_a = -1; corrupt_b = -1;

        // Backpressure: full toggles every 3 cycles
        loop_en = 1'b0; drv_empty = 1'b1; mode = 2'b00; seed = $urandom; gen_len = 50; chk_len = 0;
        build_exp(2'b00, seed, 50);
        pulse_start();
        for (int c = 0; c < 300 && !gen_done; c++) begin
            drv_full = ((c / 3) % 2) == 1;
            tick();
        end
        drv_full = 1'b0;
        check("t4_gen_done", DW'(gen_done), 1);
        check_words(50);
        check("t4_wr_while_full", full_wr, 0);
        check("t4_gen_count", gen_count, 50);

        // Continuous run, stop, then restart with start and stop together
        loop_en = 1'b1; mode = 2'b01; seed = $urandom; gen_len = 0; chk_len = 0;
        build_exp(2'b01, seed, 400);
        pulse_start();
        tick(200);
        pulse_stop();
        tick(2);
        check("t5_gen_done", DW'(gen_done), 1);
        check("t5_chk_done", DW'(chk_done), 1);
        check("t5_err_count", err_count, 0);
        check("t5_gen_vs_mon", gen_count, got_q.size());
        check("t5_chk_plus_fifo", chk_count + CW'(fifo_cnt), gen_count);
        len = got_q.size();
        check_words(len);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t5_restart_gen_count", gen_count, 0);
        check("t5_restart_chk_count", chk_count, 0);
        check("t5_restart_din", gen_din, exp_arr[0]);
        check("t5_restart_running", DW'({gen_done, chk_done}), 0);
        tick(50);
        pulse_stop();
        tick(2);
        check("t5b_err_count", err_count, 0);
        check("t5b_done", DW'({gen_done, chk_done}), 2'b11);
        len = got_q.size();
        check_words(len);

        // Randomized seed and length across every mode encoding
        for (int r = 0; r < 4; r++) begin
            mode = 2'(r); seed = $urandom; len = $urandom_range(20, 80);
            gen_len = CW'(len); chk_len = CW'(len);
            build_exp(2'(r), seed, len);
            pulse_start();
            wait_done(1000);
            check_words(len);
            check($sformatf("rnd%0d_chk_count", r), chk_count, len);
            check($sformatf("rnd%0d_err_count", r), err_count, 0);
        end
        loop_en = 1'b0;

        // Saturation on the narrow instance, then reset mid-run
        mode = 2'b00; seed = 32'h0; s_len = '0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        nerr = 0; first_bad = '0;
        for (int k = 0; k < 20; k++) begin
            bad = (k < 3) ? 32'(k) : (32'(k) ^ ($urandom | 32'h1));
            if (k >= 3) begin
                if (nerr == 0) first_bad = bad;
                nerr++;
            end
            s_valid = 1'b1; s_dout = bad;
            tick();
        end
        s_valid = 1'b0;
        tick();
        check("t6_err_sat", s_err_count, (nerr > 15) ? 15 : nerr);
        check("t6_first_idx", s_first_idx, 3);
        check("t6_first_data", s_first_data, first_bad);
        check("t6_flag", DW'(s_flag), 1);
        check("t6_chk_count_wrap", s_chk_count, 20 % 16);
        s_valid = 1'b1; s_dout = 32'hDEAD_BEEF;
        tick();
        check("t6_err_still_sat", s_err_count, 15);
        rst = 1'b1;
        tick();
        check("t6_rst_chk_count", s_chk_count, 0);
        check("t6_rst_err_count", s_err_count, 0);
        check("t6_rst_flag", DW'(s_flag), 0);
        check("t6_rst_first", DW'({s_first_idx, s_first_data}), 0);
        check("t6_rst_ctrl", DW'({s_rd_en, s_chk_done, s_gen_done}), 0);
        check("t6_rst_main_count", gen_count, 0);
        rst = 1'b0;
        tick();
        check("t6_post_rst_valid_ignored", DW'({s_err_count, s_chk_count}), 0);
        s_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
